cofre_controle: RTL and testbench
=================================

// Module: cofre_controle
// PURPOSE
//  Sequential front end of the safe (cofre): stores the programmed password and captures user attempts.
//  Drives the combinational checker's senha/tentativa inputs and samples its led0/led1/led2 verdict.
//  Counts failed attempts and enforces a timed lockout.
//  Sits between keypad/switch inputs and the checker; owns all safe state.
// PARAMETERS
//  WIDTH           4   bit width of senha/tentativa
//  SENHA_INICIAL   0   password value loaded on reset
//  MAX_FALHAS      3   consecutive failures that trigger lockout (>=1)
//  BLOQUEIO_CICLOS 16  lockout duration in clk cycles (>=1)
//  TEMPO_ABERTO    32  auto-close timeout, cycles (used only with COFRE_AUTO_FECHAR_EN)
// PORTS
//  clk        in  1      clock, rising edge
//  reset      in  1      synchronous, active-high
//  tentativa_in in WIDTH attempt from user switches
//  enviar     in  1      one-cycle pulse: submit tentativa_in
//  senha_nova in  WIDTH  new password value
//  gravar     in  1      one-cycle pulse: program senha_nova (honoured only in ABERTO)
//  fechar     in  1      one-cycle pulse: close the open safe
//  led0_in    in  1      checker verdict: exact match
//  led1_in    in  1      checker verdict: |diff| <= 3
//  led2_in    in  1      checker verdict: wrong, |diff| > 3
//  senha      out WIDTH  registered password, to checker
//  tentativa  out WIDTH  registered attempt, to checker
//  aberto     out 1      safe open (state ABERTO)
//  perto      out 1      last failed attempt was within 3
//  erro       out 1      last attempt failed
//  bloqueado  out 1      lockout active
//  ocupado    out 1      attempt under evaluation (state CHECK)
//  falhas     out 2      consecutive failure count, saturating at MAX_FALHAS
// BEHAVIOUR
//  Reset: state IDLE; senha=SENHA_INICIAL; tentativa=0; falhas=0; all 1-bit outputs 0; timers 0.
//  Reset mid-operation (any state) aborts everything: same values next cycle, senha included.
//  FSM IDLE -> CHECK -> {IDLE | ABERTO | BLOQUEIO}; ABERTO -> IDLE; BLOQUEIO -> IDLE.
//  IDLE: enviar=1 -> tentativa<=tentativa_in; perto, erro cleared; go to CHECK.
//  CHECK: exactly 1 cycle, ocupado=1; led* sampled at the end of this cycle.
//   led0_in=1 (takes priority over led1/led2) -> ABERTO, aberto=1, falhas=0.
//   Otherwise: erro=1, perto=led1_in, falhas+1.
//   If the new falhas==MAX_FALHAS -> BLOQUEIO, timer<=BLOQUEIO_CICLOS-1, bloqueado=1; else -> IDLE.
//  Latency: enviar at cycle N -> aberto/erro valid at N+2.
//  BLOQUEIO: timer decrements each cycle; at 0 -> IDLE, bloqueado=0, falhas=0; erro/perto held.
//  ABERTO: gravar=1 -> senha<=senha_nova. fechar=1 -> IDLE, aberto=0.
//   gravar+fechar in the same cycle: the write happens and the safe closes.
//  enviar is ignored outside IDLE (no queueing). gravar is ignored outside ABERTO. fechar is ignored outside ABERTO.
//  falhas counts only consecutive failures; it clears on success or when lockout ends.
// CONFIGURATION
//  COFRE_AUTO_FECHAR_EN defined:
//   ABERTO holds an idle counter, reset to 0 on entry and on every gravar.
//   When the counter reaches TEMPO_ABERTO-1 -> IDLE, aberto=0.
//   fechar still closes immediately.
//  Not defined: no counter; ABERTO persists until fechar or reset.
// TESTING
//  1 Reset, then enviar with tentativa_in=0 (checker sees 0 vs 0) -> aberto=1 at N+2, falhas=0.
//  2 senha=5, enviar 7 -> erro=1, perto=1, falhas=1; enviar 12 -> erro=1, perto=0, falhas=2.
//  3 senha=5, three wrong attempts (9, 1, 14) -> bloqueado=1 for exactly 16 cycles.
//    enviar during lockout is ignored; afterwards falhas=0 and state IDLE.
//  4 Open, gravar senha_nova=10 with fechar in the same cycle -> senha=10, aberto=0.
//    Next enviar 5 -> erro=1; enviar 10 -> aberto=1.
//  5 gravar pulsed in IDLE or BLOQUEIO -> senha unchanged. reset asserted during CHECK or BLOQUEIO -> all reset values next cycle.
//  6 COFRE_AUTO_FECHAR_EN with TEMPO_ABERTO=32: open, idle -> aberto drops after 32 cycles; a gravar at cycle 20 restarts the count.

Source files
------------

// File: rtl/cofre_controle.sv
// cofre_controle: sequential front end of the safe.
// Holds the programmed password (senha) and the last user attempt (tentativa), feeds both to an
// external combinational checker and samples its led0/led1/led2 verdict one cycle later. Counts
// consecutive failures and enforces a timed lockout after MAX_FALHAS of them.
//
// Ports:
//   clk, reset           clock (rising edge) and synchronous active-high reset
//   tentativa_in, enviar attempt value and one-cycle submit pulse (honoured in IDLE)
//   senha_nova, gravar   new password and one-cycle program pulse (honoured in ABERTO)
//   fechar               one-cycle close pulse (honoured in ABERTO)
//   led0_in/1_in/2_in    checker verdict: exact / within 3 / wrong by more than 3
//   senha, tentativa     registered password and attempt, to the checker
//   aberto, ocupado,     state decodes: ABERTO, CHECK, BLOQUEIO
//   bloqueado
//   perto, erro          last failed attempt was close / last attempt failed
//   falhas               consecutive failure count
//
// Optional feature: define COFRE_AUTO_FECHAR_EN to close the safe automatically after
// TEMPO_ABERTO cycles in ABERTO without a gravar.

module cofre_controle #(
   parameter int unsigned      WIDTH           = 4,
   parameter logic [WIDTH-1:0] SENHA_INICIAL   = '0,
   parameter int unsigned      MAX_FALHAS      = 3,
   parameter int unsigned      BLOQUEIO_CICLOS = 16,
   parameter int unsigned      TEMPO_ABERTO    = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] tentativa_in,
   input  logic             enviar,
   input  logic [WIDTH-1:0] senha_nova,
   input  logic             gravar,
   input  logic             fechar,
   input  logic             led0_in,
   input  logic             led1_in,
   input  logic             led2_in,
   output logic [WIDTH-1:0] senha,
   output logic [WIDTH-1:0] tentativa,
   output logic             aberto,
   output logic             perto,
   output logic             erro,
   output logic             bloqueado,
   output logic             ocupado,
   output logic [1:0]       falhas
);

   localparam logic [1:0] StIdle     = 2'd0;
   localparam logic [1:0] StCheck    = 2'd1;
   localparam logic [1:0] StAberto   = 2'd2;
   localparam logic [1:0] StBloqueio = 2'd3;

   localparam int unsigned BloqW = (BLOQUEIO_CICLOS > 1) ? $clog2(BLOQUEIO_CICLOS) : 1;
   localparam logic [BloqW-1:0] BloqIni = BloqW'(BLOQUEIO_CICLOS - 1);

   localparam int unsigned AbreW = (TEMPO_ABERTO > 1) ? $clog2(TEMPO_ABERTO) : 1;
   localparam logic [AbreW-1:0] AbreFim = AbreW'(TEMPO_ABERTO - 1);

   localparam logic [2:0] MaxFalhas = 3'(MAX_FALHAS);

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] senha_q, senha_d;
   logic [WIDTH-1:0] tentativa_q, tentativa_d;
   logic             perto_q, perto_d;
   logic             erro_q, erro_d;
   logic [1:0]       falhas_q, falhas_d;
   logic [BloqW-1:0] timer_q, timer_d;
   logic [2:0]       falhas_inc;

`ifdef COFRE_AUTO_FECHAR_EN
   logic [AbreW-1:0] abre_cnt_q, abre_cnt_d;
`else
   logic unused_tempo;
   assign unused_tempo = ^AbreFim;
`endif

   // led2 is implied by !led0 && !led1; any non-exact verdict counts as a failure.
   logic unused_led2;
   assign unused_led2 = led2_in;

   // Widened by one bit so the saturation compare cannot wrap.
   assign falhas_inc = {1'b0, falhas_q} + 3'd1;

   always_comb begin
      state_d     = state_q;
      senha_d     = senha_q;
      tentativa_d = tentativa_q;
      perto_d     = perto_q;
      erro_d      = erro_q;
      falhas_d    = falhas_q;
      timer_d     = timer_q;
`ifdef COFRE_AUTO_FECHAR_EN
      abre_cnt_d  = abre_cnt_q;
`endif
      case (state_q)
         StIdle: begin
            if (enviar) begin
               tentativa_d = tentativa_in;
               perto_d     = 1'b0;
               erro_d      = 1'b0;
               state_d     = StCheck;
            end
         end
         StCheck: begin
            if (led0_in) begin
               state_d  = StAberto;
               falhas_d = 2'd0;
`ifdef COFRE_AUTO_FECHAR_EN
               abre_cnt_d = '0;
`endif
            end else begin
               erro_d  = 1'b1;
               perto_d = led1_in;
               if (falhas_inc >= MaxFalhas) begin
                  falhas_d = MaxFalhas[1:0];
                  timer_d  = BloqIni;
                  state_d  = StBloqueio;
               end else begin
                  falhas_d = falhas_inc[1:0];
                  state_d  = StIdle;
               end
            end
         end
         StAberto: begin
            // A write in the same cycle as fechar still lands.
            if (gravar) begin
               senha_d = senha_nova;
            end
            if (fechar) begin
               state_d = StIdle;
            end
`ifdef COFRE_AUTO_FECHAR_EN
            else if (gravar) begin
               abre_cnt_d = '0;
            end else if (abre_cnt_q == AbreFim) begin
               state_d = StIdle;
            end else begin
               abre_cnt_d = abre_cnt_q + 1'b1;
            end
`endif
         end
         StBloqueio: begin
            if (timer_q == '0) begin
               state_d  = StIdle;
               falhas_d = 2'd0;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         senha_q     <= SENHA_INICIAL;
         tentativa_q <= '0;
         perto_q     <= 1'b0;
         erro_q      <= 1'b0;
         falhas_q    <= 2'd0;
         timer_q     <= '0;
      end else begin
         state_q     <= state_d;
         senha_q     <= senha_d;
         tentativa_q <= tentativa_d;
         perto_q     <= perto_d;
         erro_q      <= erro_d;
         falhas_q    <= falhas_d;
         timer_q     <= timer_d;
      end
   end

`ifdef COFRE_AUTO_FECHAR_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         abre_cnt_q <= '0;
      end else begin
         abre_cnt_q <= abre_cnt_d;
      end
   end
`endif

   assign senha     = senha_q;
   assign tentativa = tentativa_q;
   assign perto     = perto_q;
   assign erro      = erro_q;
   assign falhas    = falhas_q;
   assign aberto    = (state_q == StAberto);
   assign ocupado   = (state_q == StCheck);
   assign bloqueado = (state_q == StBloqueio);

endmodule

// File: tb/tb_cofre_controle.sv
// Testbench for cofre_controle: models the combinational checker and drives directed vectors.

module tb_cofre_controle;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] tentativa_in = '0;
   logic       enviar = 1'b0;
   logic [3:0] senha_nova = '0;
   logic       gravar = 1'b0;
   logic       fechar = 1'b0;
   logic       led0_in, led1_in, led2_in;
   logic [3:0] senha, tentativa;
   logic       aberto, perto, erro, bloqueado, ocupado;
   logic [1:0] falhas;
   logic [3:0] diff;

   int n_total = 0;
   int n_bad   = 0;
   int cnt;

   cofre_controle #(
      .WIDTH          (4),
      .SENHA_INICIAL  (4'd0),
      .MAX_FALHAS     (3),
      .BLOQUEIO_CICLOS(16),
      .TEMPO_ABERTO   (32)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .tentativa_in (tentativa_in),
      .enviar       (enviar),
      .senha_nova   (senha_nova),
      .gravar       (gravar),
      .fechar       (fechar),
      .led0_in      (led0_in),
      .led1_in      (led1_in),
      .led2_in      (led2_in),
      .senha        (senha),
      .tentativa    (tentativa),
      .aberto       (aberto),
      .perto        (perto),
      .erro         (erro),
      .bloqueado    (bloqueado),
      .ocupado      (ocupado),
      .falhas       (falhas)
   );

   always #5 clk = ~clk;

   // Combinational checker the controller talks to.
   always_comb begin
      diff    = (senha > tentativa) ? senha - tentativa : tentativa - senha;
      led0_in = (diff == 4'd0);
      led1_in = (diff != 4'd0) && (diff <= 4'd3);
      led2_in = (diff > 4'd3);
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // enviar pulse, then one CHECK cycle: verdict visible on return (N+2).
   task automatic submit(input logic [3:0] v);
      tentativa_in = v;
      enviar = 1'b1;
      tick();
      enviar = 1'b0;
      tick();
   endtask

   task automatic close_safe();
      fechar = 1'b1;
      tick();
      fechar = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      check_val("rst_senha", 32'(senha), 0);
      check_val("rst_tent", 32'(tentativa), 0);
      check_val("rst_falhas", 32'(falhas), 0);
      check_val("rst_flags", 32'({aberto, perto, erro, bloqueado, ocupado}), 0);

      // 1: 0 vs 0 opens at N+2
      tentativa_in = 4'd0;
      enviar = 1'b1;
      tick();
      enviar = 1'b0;
      check_val("t1_ocupado", 32'(ocupado), 1);
      check_val("t1_aberto_n1", 32'(aberto), 0);
      tick();
      check_val("t1_aberto", 32'(aberto), 1);
      check_val("t1_falhas", 32'(falhas), 0);

      // program 5 and close together
      senha_nova = 4'd5;
      gravar = 1'b1;
      fechar = 1'b1;
      tick();
      gravar = 1'b0;
      fechar = 1'b0;
      check_val("prog5_senha", 32'(senha), 5);
      check_val("prog5_aberto", 32'(aberto), 0);

      // 2: near miss, then far miss
      submit(4'd7);
      check_val("t2a_erro", 32'(erro), 1);
      check_val("t2a_perto", 32'(perto), 1);
      check_val("t2a_falhas", 32'(falhas), 1);
      submit(4'd12);
      check_val("t2b_erro", 32'(erro), 1);
      check_val("t2b_perto", 32'(perto), 0);
      check_val("t2b_falhas", 32'(falhas), 2);
      submit(4'd5);
      check_val("t2c_aberto", 32'(aberto), 1);
      check_val("t2c_falhas", 32'(falhas), 0);
      check_val("t2c_erro", 32'(erro), 0);
      close_safe();

      // 3: three misses -> 16-cycle lockout, enviar/gravar ignored inside
      submit(4'd9);
      check_val("t3a_perto", 32'(perto), 0);
      submit(4'd1);
      submit(4'd14);
      check_val("t3_bloq", 32'(bloqueado), 1);
      check_val("t3_falhas_sat", 32'(falhas), 3);
      cnt = 1;
      for (int i = 0; i < 100; i++) begin
         if (cnt == 5) begin
            tentativa_in = 4'd5;
            senha_nova = 4'd2;
            enviar = 1'b1;
            gravar = 1'b1;
         end
         tick();
         enviar = 1'b0;
         gravar = 1'b0;
         if (!bloqueado) break;
         cnt++;
      end
      check_val("t3_bloq_len", 32'(cnt), 16);
      check_val("t3_falhas_end", 32'(falhas), 0);
      check_val("t3_idle", 32'({aberto, ocupado, bloqueado}), 0);
      check_val("t3_erro_held", 32'(erro), 1);
      check_val("t3_senha", 32'(senha), 5);
      check_val("t3_tent", 32'(tentativa), 14);

      // 4: gravar+fechar together, then new password takes effect
      submit(4'd5);
      check_val("t4_open", 32'(aberto), 1);
      senha_nova = 4'd10;
      gravar = 1'b1;
      fechar = 1'b1;
      tick();
      gravar = 1'b0;
      fechar = 1'b0;
      check_val("t4_senha", 32'(senha), 10);
      check_val("t4_aberto", 32'(aberto), 0);
      submit(4'd5);
      check_val("t4_old_erro", 32'(erro), 1);
      check_val("t4_old_aberto", 32'(aberto), 0);
      submit(4'd10);
      check_val("t4_new_aberto", 32'(aberto), 1);
      close_safe();

      // 5: gravar in IDLE ignored; reset during CHECK and BLOQUEIO
      senha_nova = 4'd3;
      gravar = 1'b1;
      tick();
      gravar = 1'b0;
      check_val("t5_idle_gravar", 32'(senha), 10);
      tentativa_in = 4'd7;
      enviar = 1'b1;
      tick();
      enviar = 1'b0;
      check_val("t5_in_check", 32'(ocupado), 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_val("t5_rc_senha", 32'(senha), 0);
      check_val("t5_rc_tent", 32'(tentativa), 0);
      check_val("t5_rc_flags", 32'({aberto, perto, erro, bloqueado, ocupado}), 0);
      submit(4'd3);
      check_val("t5_perto_edge", 32'(perto), 1);
      submit(4'd4);
      check_val("t5_far_edge", 32'(perto), 0);
      submit(4'd4);
      check_val("t5_bloq", 32'(bloqueado), 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_val("t5_rb_flags", 32'({aberto, perto, erro, bloqueado, ocupado}), 0);
      check_val("t5_rb_falhas", 32'(falhas), 0);

`ifdef COFRE_AUTO_FECHAR_EN
      // 6: auto-close after 32 cycles; gravar at cycle 20 restarts the count
      submit(4'd0);
      cnt = 1;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (!aberto) break;
         cnt++;
      end
      check_val("t6_auto_len", 32'(cnt), 32);
      submit(4'd0);
      cnt = 1;
      for (int i = 0; i < 200; i++) begin
         if (cnt == 20) begin
            senha_nova = 4'd0;
            gravar = 1'b1;
         end
         tick();
         gravar = 1'b0;
         if (!aberto) break;
         cnt++;
      end
      check_val("t6_restart_len", 32'(cnt), 52);
`else
      // without auto-close the safe stays open
      submit(4'd0);
      for (int i = 0; i < 40; i++) tick();
      check_val("t6_stays_open", 32'(aberto), 1);
      close_safe();
      check_val("t6_closed", 32'(aberto), 0);
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
